// File: rtl/mem_subsystem_pkg.sv
// Shared constants for the stack-processor memory subsystem.
// Holds the data word width, the default RAM depth, the memory-mapped IO
// addresses, and the encoding of the read-data source.
package mem_subsystem_pkg;

  localparam int          WORD_W         = 16;
  localparam int          RAM_ADDR_W_DEF = 10;
  localparam int          RAM_DEPTH_DEF  = 1 << RAM_ADDR_W_DEF;
  localparam logic [15:0] IO_IN_ADDR_DEF  = 16'hFFFE;
  localparam logic [15:0] IO_OUT_ADDR_DEF = 16'hFFFF;

  // Selects which source drives the read-data output during the current cycle.
  typedef enum logic {
    RD_RAM = 1'b0,  // registered RAM output
    RD_IO  = 1'b1   // registered IO value (or zero after reset)
  } rd_sel_e;

endpackage

// File: rtl/mem_subsystem_ram.sv
// Single-port RAM with a registered, write-first read port.
// The coding style is chosen so that synthesis infers block RAM.
// Ports:
//   clk      - clock
//   we_i     - write enable
//   addr_i   - word index
//   wdata_i  - write data
//   rdata_o  - registered read data (new data on a same-cycle write)
module mem_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [1 << ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // No reset: RAM contents and the read register survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_q       <= wdata_i;
    end else begin
      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_subsystem.sv
// Memory subsystem for the 16-bit multicycle stack processor.
// Contains the PC/ALU address mux, a word RAM, memory-mapped input and output
// ports at the top of the address space, the registered read-data path,
// and the instruction register.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   IorD        - address select (0: PCWire, 1: ALUoutWire)
//   wea         - write enable
//   IRWrite     - IR load enable
//   ALUoutWire  - data address
//   PCWire      - instruction address
//   bWire       - write data
//   input_IO    - input port value
//   IRw         - instruction register
//   Memoutw     - registered read data
//   output_IO   - output port register
module mem_subsystem
  import mem_subsystem_pkg::*;
#(
  parameter int          RAM_ADDR_W  = RAM_ADDR_W_DEF,
  parameter logic [15:0] IO_IN_ADDR  = IO_IN_ADDR_DEF,
  parameter logic [15:0] IO_OUT_ADDR = IO_OUT_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IorD,
  input  logic              wea,
  input  logic              IRWrite,
  input  logic [WORD_W-1:0] ALUoutWire,
  input  logic [WORD_W-1:0] PCWire,
  input  logic [WORD_W-1:0] bWire,
  input  logic [WORD_W-1:0] input_IO,
  output logic [WORD_W-1:0] IRw,
  output logic [WORD_W-1:0] Memoutw,
  output logic [WORD_W-1:0] output_IO
);

  logic [WORD_W-1:0] addr;
  logic              is_io_in, is_io_out;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  logic [WORD_W-1:0] out_q, out_d;
  logic [WORD_W-1:0] io_q, io_d;
  rd_sel_e           sel_q, sel_d;
  logic [WORD_W-1:0] ir_q, ir_d;

  assign addr      = IorD ? ALUoutWire : PCWire;
  assign is_io_in  = (addr == IO_IN_ADDR);
  assign is_io_out = (addr == IO_OUT_ADDR);
  // Upper address bits are not decoded, so RAM aliases across the map.
  assign ram_we    = wea && !reset && !is_io_in && !is_io_out;

  mem_ram #(
    .ADDR_W (RAM_ADDR_W),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (addr[RAM_ADDR_W-1:0]),
    .wdata_i (bWire),
    .rdata_o (ram_rdata)
  );

  // The RAM read register cannot be reset, so the read source is registered
  // alongside it; reset forces the IO path with a zero value.
  assign Memoutw = (sel_q == RD_RAM) ? ram_rdata : io_q;

  always_comb begin
    out_d = out_q;
    io_d  = '0;
    sel_d = RD_RAM;
    ir_d  = ir_q;
    if (wea && is_io_out) out_d = bWire;
    if (is_io_in) begin
      sel_d = RD_IO;
      io_d  = input_IO;
    end else if (is_io_out) begin
      sel_d = RD_IO;
      io_d  = out_q;  // reads return the value before this edge's write
    end
    if (IRWrite) ir_d = Memoutw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      io_q  <= '0;
      sel_q <= RD_IO;
      ir_q  <= '0;
    end else begin
      out_q <= out_d;
      io_q  <= io_d;
      sel_q <= sel_d;
      ir_q  <= ir_d;
    end
  end

  assign IRw       = ir_q;
  assign output_IO = out_q;

endmodule

// File: tb/tb_mem_subsystem.sv
// Scoreboard bench for mem_subsystem: directed steps push the expected
// post-edge outputs into a queue, a negedge monitor pops and compares.
module tb_mem_subsystem;

  logic        clk = 1'b0;
  logic        reset, IorD, wea, IRWrite;
  logic [15:0] ALUoutWire, PCWire, bWire, input_IO;
  logic [15:0] IRw, Memoutw, output_IO;

  typedef struct {
    string       name;
    logic [15:0] ir, m, o;
    bit          c_ir, c_m, c_o;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  mem_subsystem dut (
    .clk        (clk),
    .reset      (reset),
    .IorD       (IorD),
    .wea        (wea),
    .IRWrite    (IRWrite),
    .ALUoutWire (ALUoutWire),
    .PCWire     (PCWire),
    .bWire      (bWire),
    .input_IO   (input_IO),
    .IRw        (IRw),
    .Memoutw    (Memoutw),
    .output_IO  (output_IO)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are settled at the negedge following each step.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.c_ir) begin
        checks++;
        if (IRw !== e.ir) begin
          errors++;
          $display("FAIL %s IRw got %h expected %h", e.name, IRw, e.ir);
        end
      end
      if (e.c_m) begin
        checks++;
        if (Memoutw !== e.m) begin
          errors++;
          $display("FAIL %s Memoutw got %h expected %h", e.name, Memoutw, e.m);
        end
      end
      if (e.c_o) begin
        checks++;
        if (output_IO !== e.o) begin
          errors++;
          $display("FAIL %s output_IO got %h expected %h", e.name, output_IO, e.o);
        end
      end
    end
  end

  // One clock with the given inputs, then queue what must hold after the edge.
  task automatic step(input string name, input logic rst, input logic sel,
                      input logic we, input logic irw, input logic [15:0] a,
                      input logic [15:0] d,
                      input bit c_ir, input logic [15:0] ir,
                      input bit c_m,  input logic [15:0] m,
                      input bit c_o,  input logic [15:0] o);
    exp_t e;
    reset = rst; IorD = sel; wea = we; IRWrite = irw; bWire = d;
    if (sel) ALUoutWire = a; else PCWire = a;
    @(posedge clk);
    #1;
    e.name = name; e.ir = ir; e.m = m; e.o = o;
    e.c_ir = c_ir; e.c_m = c_m; e.c_o = c_o;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; IorD = 1'b0; wea = 1'b0; IRWrite = 1'b0;
    ALUoutWire = '0; PCWire = '0; bWire = '0; input_IO = '0;
    @(negedge clk);
    //   name         rst sel we ir  addr     data       IR            Memoutw         output_IO
    step("reset",     1, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 1, 16'h0000, 1, 16'h0000);
    step("wr5",       0, 0, 1, 0, 16'h0005, 16'h8888, 1, 16'h0000, 1, 16'h8888, 1, 16'h0000);
    step("rd5",       0, 0, 0, 0, 16'h0005, 16'h0000, 1, 16'h0000, 1, 16'h8888, 0, 16'h0000);
    step("irload",    0, 0, 0, 1, 16'h0005, 16'h0000, 1, 16'h8888, 1, 16'h8888, 0, 16'h0000);
    step("irhold",    0, 0, 0, 0, 16'h0006, 16'h0000, 1, 16'h8888, 0, 16'h0000, 0, 16'h0000);
    step("wr1_alu",   0, 1, 1, 0, 16'h0001, 16'h1234, 0, 16'h0000, 1, 16'h1234, 0, 16'h0000);
    step("rd5_pc",    0, 0, 0, 0, 16'h0005, 16'h0000, 0, 16'h0000, 1, 16'h8888, 0, 16'h0000);
    step("rd1_alu",   0, 1, 0, 0, 16'h0001, 16'h0000, 0, 16'h0000, 1, 16'h1234, 0, 16'h0000);
    step("alias401",  0, 1, 0, 0, 16'h0401, 16'h0000, 0, 16'h0000, 1, 16'h1234, 0, 16'h0000);
    step("wr3ff",     0, 1, 1, 0, 16'h03FF, 16'h5A5A, 0, 16'h0000, 1, 16'h5A5A, 0, 16'h0000);
    step("wr3fe",     0, 1, 1, 0, 16'h03FE, 16'h7777, 0, 16'h0000, 1, 16'h7777, 0, 16'h0000);
    step("wr_out",    0, 1, 1, 0, 16'hFFFF, 16'hA5A5, 0, 16'h0000, 1, 16'h0000, 1, 16'hA5A5);
    step("rd_out",    0, 1, 0, 0, 16'hFFFF, 16'h0000, 0, 16'h0000, 1, 16'hA5A5, 1, 16'hA5A5);
    step("rd3ff",     0, 1, 0, 0, 16'h03FF, 16'h0000, 0, 16'h0000, 1, 16'h5A5A, 0, 16'h0000);
    input_IO = 16'h00C3;
    step("rd_in_wr",  0, 1, 1, 0, 16'hFFFE, 16'h1111, 0, 16'h0000, 1, 16'h00C3, 1, 16'hA5A5);
    step("rd3fe",     0, 1, 0, 0, 16'h03FE, 16'h0000, 0, 16'h0000, 1, 16'h7777, 0, 16'h0000);
    step("irw_wea",   0, 1, 1, 1, 16'h0002, 16'h2222, 1, 16'h7777, 1, 16'h2222, 0, 16'h0000);
    step("wr7",       0, 1, 1, 0, 16'h0007, 16'h0C0C, 1, 16'h7777, 1, 16'h0C0C, 0, 16'h0000);
    step("rst_wr7",   1, 1, 1, 1, 16'h0007, 16'hBEEF, 1, 16'h0000, 1, 16'h0000, 1, 16'h0000);
    step("rd7_post",  0, 1, 0, 0, 16'h0007, 16'h0000, 1, 16'h0000, 1, 16'h0C0C, 1, 16'h0000);
    step("rd2",       0, 1, 0, 0, 16'h0002, 16'h0000, 0, 16'h0000, 1, 16'h2222, 0, 16'h0000);
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
